// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_adder_ctrl.
// The master side produces operands and consumes results; the slave side is the sequencer.
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start_valid;
    logic         start_ready;
    logic         op_sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C_in;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] SUM;
    logic         C_out;
    logic         ovf;
    logic         busy;

    modport master (
        output start_valid, op_sub, A, B, C_in, res_ready,
        input  start_ready, res_valid, SUM, C_out, ovf, busy
    );

    modport slave (
        input  start_valid, op_sub, A, B, C_in, res_ready,
        output start_ready, res_valid, SUM, C_out, ovf, busy
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract computed one nibble per clock, LSB first, through a single
// time-shared 4-bit ripple-carry adder with the carry chained in a register.

module ripple_FA (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C_in,
    output logic [3:0] SUM,
    output logic       C_out
);
    // Bit-serial carry ripple through four full adders
    always_comb begin
        logic carry_v;
        carry_v = C_in;
        SUM     = 4'h0;
        for (int i = 0; i < 4; i++) begin
            SUM[i]  = A[i] ^ B[i] ^ carry_v;
            carry_v = (A[i] & B[i]) | (carry_v & (A[i] ^ B[i]));
        end
        C_out = carry_v;
    end
endmodule

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            cy_q, cy_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            c_out_q, c_out_d;
    logic            ovf_q, ovf_d;

    logic [IW+1:0]   nib_sh_s;
    logic [W-1:0]    a_shift_s;
    logic [W-1:0]    b_shift_s;
    logic [3:0]      a_nib_s;
    logic [3:0]      b_eff_nib_s;
    logic [3:0]      fa_sum_s;
    logic            fa_cout_s;
    logic [W-1:0]    nib_mask_s;
    logic [W-1:0]    nib_ins_s;
    logic            last_nib_s;

    // Nibble select: b_q already holds ~B for a subtract
    always_comb begin
        nib_sh_s    = {idx_q, 2'b00};
        a_shift_s   = a_q >> nib_sh_s;
        b_shift_s   = b_q >> nib_sh_s;
        a_nib_s     = a_shift_s[3:0];
        b_eff_nib_s = b_shift_s[3:0];
        nib_mask_s  = W'(4'hF) << nib_sh_s;
        nib_ins_s   = W'(fa_sum_s) << nib_sh_s;
        last_nib_s  = (idx_q == IW'(NIBBLES - 1));
    end

    ripple_FA u_fa (
        .A     (a_nib_s),
        .B     (b_eff_nib_s),
        .C_in  (cy_q),
        .SUM   (fa_sum_s),
        .C_out (fa_cout_s)
    );

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cy_d    = cy_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.op_sub ? ~bus.B : bus.B;
                    cy_d    = bus.op_sub ? 1'b1 : bus.C_in;
                    idx_d   = {IW{1'b0}};
                    sum_d   = {W{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d = (sum_q & ~nib_mask_s) | nib_ins_s;
                cy_d  = fa_cout_s;
                if (last_nib_s) begin
                    c_out_d = fa_cout_s;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) & (fa_sum_s[3] != a_q[W-1]);
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= {IW{1'b0}};
            cy_q    <= 1'b0;
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            sum_q   <= {W{1'b0}};
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.start_ready = (state_q == S_IDLE);
    assign bus.res_valid   = (state_q == S_DONE);
    assign bus.busy        = (state_q == S_RUN) | (state_q == S_DONE);
    assign bus.SUM         = sum_q;
    assign bus.C_out       = c_out_q;
    assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: transaction-level arithmetic model with a per-cycle compare,
// plus directed vectors carrying hand-computed results.
module tb_nibble_serial_adder_ctrl;
    localparam int NIB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    nibble_serial_adder_ctrl_if #(.NIBBLES(NIB)) bus ();

    nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {carry, sum}
    function automatic logic [16:0] ref_result(input logic sub, input logic [15:0] a,
                                               input logic [15:0] b, input logic cin);
        if (sub) return {1'b0, a} + (17'h10000 - {1'b0, b});
        else     return {1'b0, a} + {1'b0, b} + {16'h0, cin};
    endfunction

    function automatic logic ref_ovf(input logic sub, input logic [15:0] a,
                                     input logic [15:0] b, input logic [15:0] r);
        if (sub) return (a[15] != b[15]) && (r[15] != a[15]);
        else     return (a[15] == b[15]) && (r[15] != a[15]);
    endfunction

    // Model: mode 0 idle, 1 computing, 2 result presented
    int          m_mode = 0;
    int          m_left = 0;
    bit          m_init = 1'b0;
    bit          m_chk  = 1'b0;
    logic [15:0] p_sum, e_sum;
    logic        p_c, p_o, e_c, e_o;

    always @(posedge clk) begin
        logic [16:0] r;
        if (rst) begin
            m_mode = 0; m_init = 1'b1; m_chk = 1'b1;
            e_sum = 16'h0; e_c = 1'b0; e_o = 1'b0;
        end else if (m_init) begin
            case (m_mode)
                0: if (bus.start_valid) begin
                    r = ref_result(bus.op_sub, bus.A, bus.B, bus.C_in);
                    p_sum = r[15:0]; p_c = r[16];
                    p_o = ref_ovf(bus.op_sub, bus.A, bus.B, r[15:0]);
                    m_left = NIB; m_mode = 1; m_chk = 1'b0;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 2; m_chk = 1'b1;
                        e_sum = p_sum; e_c = p_c; e_o = p_o;
                    end
                end
                default: if (bus.res_ready) begin
                    m_mode = 0; m_chk = 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("start_ready", {31'h0, bus.start_ready}, {31'h0, m_mode == 0});
            check("res_valid",   {31'h0, bus.res_valid},   {31'h0, m_mode == 2});
            check("busy",        {31'h0, bus.busy},        {31'h0, m_mode != 0});
            if (m_chk) begin
                check("model_sum",   {16'h0, bus.SUM},   {16'h0, e_sum});
                check("model_c_out", {31'h0, bus.C_out}, {31'h0, e_c});
                check("model_ovf",   {31'h0, bus.ovf},   {31'h0, e_o});
            end
        end
    end

    task automatic run_op(input string tag, input logic sub, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic [15:0] es,
                          input logic ec, input logic eo, input int bp);
        int lat;
        lat = 0;
        while (!bus.start_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_ready_wait"}, {31'h0, bus.start_ready}, 32'h1);
        bus.op_sub = sub; bus.A = a; bus.B = b; bus.C_in = cin;
        bus.start_valid = 1'b1;
        bus.res_ready = (bp == 0);
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.A = ~a; bus.B = ~b; bus.op_sub = ~sub; bus.C_in = ~cin;
        lat = 0;
        while (!bus.res_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, NIB);
        check({tag, "_sum"},   {16'h0, bus.SUM},   {16'h0, es});
        check({tag, "_c_out"}, {31'h0, bus.C_out}, {31'h0, ec});
        check({tag, "_ovf"},   {31'h0, bus.ovf},   {31'h0, eo});
        for (int k = 0; k < bp; k++) begin
            bus.start_valid = ~bus.start_valid;
            bus.A = 16'($urandom);
            bus.B = 16'($urandom);
            @(negedge clk);
            check({tag, "_bp_valid"}, {31'h0, bus.res_valid}, 32'h1);
            check({tag, "_bp_sready"}, {31'h0, bus.start_ready}, 32'h0);
            check({tag, "_bp_sum"}, {16'h0, bus.SUM}, {16'h0, es});
        end
        bus.res_ready = 1'b1;
        bus.start_valid = 1'b0;
        @(negedge clk);
        check({tag, "_post_valid"}, {31'h0, bus.res_valid}, 32'h0);
        check({tag, "_post_sready"}, {31'h0, bus.start_ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.start_valid = 1'b0; bus.op_sub = 1'b0; bus.A = 16'h0; bus.B = 16'h0;
        bus.C_in = 1'b0; bus.res_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        bus.start_valid = 1'b1;
        @(negedge clk);
        check("reset_sready", {31'h0, bus.start_ready}, 32'h1);
        check("reset_busy",   {31'h0, bus.busy}, 32'h0);
        check("reset_sum",    {16'h0, bus.SUM}, 32'h0);
        bus.start_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        run_op("add_basic",  1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        run_op("add_ripple", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op("add_cin",    1'b0, 16'h0006, 16'h000A, 1'b1, 16'h0011, 1'b0, 1'b0, 0);
        run_op("sub_ovf",    1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
        run_op("sub_borrow", 1'b1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0, 0);
        run_op("backpress",  1'b0, 16'h7000, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b1, 3);
        run_op("back2back",  1'b1, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 0);

        // Reset landing on the second RUN edge
        bus.op_sub = 1'b0; bus.A = 16'h1234; bus.B = 16'h4321; bus.C_in = 1'b0;
        bus.start_valid = 1'b1; bus.res_ready = 1'b1;
        @(negedge clk);
        bus.start_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_valid",  {31'h0, bus.res_valid}, 32'h0);
        check("rst_mid_busy",   {31'h0, bus.busy}, 32'h0);
        check("rst_mid_sready", {31'h0, bus.start_ready}, 32'h1);
        check("rst_mid_sum",    {16'h0, bus.SUM}, 32'h0);
        check("rst_mid_c_out",  {31'h0, bus.C_out}, 32'h0);
        check("rst_mid_ovf",    {31'h0, bus.ovf}, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_no_valid", {31'h0, bus.res_valid}, 32'h0);
        end
        run_op("after_rst", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that computes a multi-nibble add or subtract by time-sharing one `ripple_FA` 4-bit ripple-carry adder instance. It processes one nibble per clock, LSB first, and chains the carry through an internal register. Operands are accepted and results returned over valid/ready handshakes. It sits between an operand producer and a result consumer wherever a wide add is needed but only a 4-bit adder is affordable.

## Interface
- `NIBBLES`, default 4: number of nibbles per operand. Operand width is W = 4*NIBBLES. Legal range is 1..16.
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start_valid`, in, 1: an operand set is offered.
- `start_ready`, out, 1: the block can accept operands. It is 1 only in IDLE.
- `op_sub`, in, 1: 0 selects A+B+C_in; 1 selects A−B, with C_in ignored.
- `A`, in, W: first operand.
- `B`, in, W: second operand.
- `C_in`, in, 1: carry into nibble 0 for an add.
- `res_valid`, out, 1: the result outputs are valid. It is 1 only in DONE.
- `res_ready`, in, 1: the consumer accepts the result.
- `SUM`, out, W: result.
- `C_out`, out, 1: carry out of the top nibble. For a subtract, 1 means no borrow.
- `ovf`, out, 1: two's-complement overflow of the W-bit result.
- `busy`, out, 1: 1 in RUN or DONE.

## Operation
- The block contains exactly one `ripple_FA`. Its inputs come from the currently selected nibble: `a_nib`, `b_eff_nib`, and the carry register `cy`.
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - On `start_valid & start_ready`, the block latches A into `a_q`.
  - It latches `op_sub ? ~B : B` into `b_q`.
  - It sets `cy <= op_sub ? 1 : C_in`, `idx <= 0` and `SUM <= 0`, then goes to RUN.
- **RUN**, each cycle:
  - `SUM[4*idx +: 4] <= adder sum`.
  - `cy <= adder C_out`.
  - If `idx == NIBBLES-1`, then `C_out <= adder C_out` and `ovf <= (a_q[W-1] == b_q[W-1]) & (adder sum[3] != a_q[W-1])`, and the FSM goes to DONE.
  - Otherwise `idx <= idx+1`.
- **DONE**
  - `SUM`, `C_out` and `ovf` are held stable.
  - On `res_ready`, the FSM goes to IDLE.
- Arithmetic is modulo 2^W. No result is ever truncated or widened beyond W+1 bits (SUM plus C_out).
- Inputs A, B, `op_sub` and `C_in` are sampled only at acceptance. Later changes do not affect the operation in flight.
- `start_valid` is ignored in RUN and DONE, because `start_ready` is 0 there.
- `res_ready` is ignored outside DONE.
- During RUN, `SUM` holds partial nibbles and must not be used.
- **Reset**
  - While `rst` is high: state is IDLE, `idx=0`, `cy=0`, `SUM=0`, `C_out=0`, `ovf=0`, `res_valid=0`, `busy=0`, `start_ready=1`.
  - `start_valid` is not accepted on any edge where `rst` is high.
  - Reset asserted mid-RUN or in DONE aborts the operation. The result is discarded and no `res_valid` pulse is produced.

## Timing
- Operands are accepted on rising edge t.
- RUN occupies edges t+1 through t+NIBBLES.
- `res_valid` goes high after edge t+NIBBLES, i.e. NIBBLES cycles after acceptance. That is 4 cycles for the default.
- `res_valid` stays high until the first edge where `res_ready` is 1. The FSM leaves DONE on that edge.
- If `res_ready` is already high on the first DONE cycle, `res_valid` lasts exactly one cycle.
- `start_ready` returns to 1 in the cycle after the result handshake.
- The earliest next acceptance is therefore one cycle after the result handshake.
- Minimum throughput is one operation per NIBBLES+2 cycles.
- All outputs are registered or decoded directly from the state register. There is no combinational path from `start_valid` or `res_ready` to any output.
- The adder path is purely combinational within one cycle: from the nibble mux through `ripple_FA` to the SUM, `cy` and `C_out` registers.

## Test plan
- **Basic add** (NIBBLES=4): `A=16'h1234`, `B=16'h4321`, `C_in=0`, `op_sub=0`, `res_ready=1` → `res_valid` for 1 cycle, exactly 4 cycles after acceptance, with `SUM=16'h5555`, `C_out=0`, `ovf=0`.
- **Full carry ripple**: `A=16'hFFFF`, `B=16'h0001`, `C_in=0` → `SUM=16'h0000`, `C_out=1`, `ovf=0`. Also `A=16'h0006`, `B=16'h000A`, `C_in=1` → `SUM=16'h0011`, `C_out=0`.
- **Subtract with overflow**: `op_sub=1`, `A=16'h8000`, `B=16'h0001`, `C_in=1` (ignored) → `SUM=16'h7FFF`, `C_out=1`, `ovf=1`.
- **Subtract with borrow**: `op_sub=1`, `A=16'h0003`, `B=16'h0005` → `SUM=16'hFFFE`, `C_out=0`, `ovf=0`.
- **Backpressure**: hold `res_ready=0` for 3 DONE cycles while toggling `start_valid`, A and B → SUM, `C_out` and `ovf` stay stable, `start_ready=0`, and no new acceptance occurs. Raise `res_ready` → DONE exits on that edge, `start_ready=1` the next cycle, and a back-to-back operation is accepted and completes correctly.
- **Reset mid-operation**: assert `rst` for 1 cycle at the second RUN cycle of `16'h1234+16'h4321` → all outputs take their reset values and no `res_valid` appears. A following `16'h7FFF+16'h0001` gives `SUM=16'h8000`, `C_out=0`, `ovf=1` with normal latency.
